// File: rtl/df_i_tdm.sv
// df_i_tdm: multi-channel Direct Form I IIR filter; one shared MAC walks b0..bN, a1..aN per sample.
// Define DF_I_TDM_SATURATE_EN to clamp results (adds the sat strobe); otherwise results wrap.
module df_i_tdm #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned N           = 2,
  parameter int unsigned PRECISION   = 16,
  parameter int unsigned COEFF_WIDTH = 8,
  parameter int unsigned Q           = 6,
  localparam int unsigned CHAN_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int unsigned TAPS       = 2 * N + 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic signed [PRECISION-1:0]   x,
  input  logic [CHAN_W-1:0]             x_chan,
  input  logic                          x_valid,
  output logic                          x_ready,
  input  logic [TAPS*COEFF_WIDTH-1:0]   packed_coeffs,
  output logic signed [PRECISION-1:0]   y,
  output logic [CHAN_W-1:0]             y_chan,
  output logic                          y_valid
`ifdef DF_I_TDM_SATURATE_EN
  ,
  output logic                          sat
`endif
);

  localparam int unsigned TAP_W  = $clog2(TAPS);
  localparam int unsigned PROD_W = PRECISION + COEFF_WIDTH;
  localparam int unsigned ACC_W  = PROD_W + $clog2(TAPS) + 1;

  typedef logic signed [PRECISION-1:0] sample_t;
  typedef enum logic [1:0] {IDLE, MAC, SCALE, OUT} state_e;

  state_e                      state_q, state_d;
  logic [TAP_W-1:0]            tap_q, tap_d;
  logic signed [ACC_W-1:0]     acc_q, acc_d;
  sample_t                     x_q, x_d;
  logic [CHAN_W-1:0]           chan_q, chan_d;
  logic [TAPS*COEFF_WIDTH-1:0] coeffs_q, coeffs_d;
  sample_t                     xh_q [CHANNELS][N];
  sample_t                     xh_d [CHANNELS][N];
  sample_t                     yh_q [CHANNELS][N];
  sample_t                     yh_d [CHANNELS][N];
  sample_t                     y_q, y_d;
  logic [CHAN_W-1:0]           y_chan_q, y_chan_d;
  logic                        y_valid_q, y_valid_d;
  logic                        x_ready_q, x_ready_d;

  logic signed [COEFF_WIDTH-1:0] coef;
  sample_t                       operand;
  logic                          chan_hit;
  logic                          feedback;
  logic signed [PROD_W-1:0]      prod;
  logic signed [ACC_W-1:0]       prod_ext;
  logic signed [ACC_W-1:0]       scaled;
  sample_t                       y_new;

  // Tap operand select: coefficient by tap position, sample from the active channel's history.
  always_comb begin
    coef     = '0;
    operand  = '0;
    chan_hit = 1'b0;
    for (int i = 0; i < TAPS; i++) begin
      if (tap_q == TAP_W'(i)) coef = coeffs_q[(TAPS-i)*COEFF_WIDTH-1 -: COEFF_WIDTH];
    end
    if (tap_q == '0) operand = x_q;
    for (int c = 0; c < CHANNELS; c++) begin
      if (chan_q == CHAN_W'(c)) begin
        chan_hit = 1'b1;
        for (int k = 0; k < N; k++) begin
          if (tap_q == TAP_W'(k + 1))     operand = xh_q[c][k];
          if (tap_q == TAP_W'(N + 1 + k)) operand = yh_q[c][k];
        end
      end
    end
  end

  assign feedback = (tap_q > TAP_W'(N));
  assign prod     = PROD_W'(operand) * PROD_W'(coef);
  assign prod_ext = ACC_W'(prod);
  assign scaled   = acc_q >>> Q;

`ifdef DF_I_TDM_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-PRECISION+1){1'b0}}, {(PRECISION-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-PRECISION+1){1'b1}}, {(PRECISION-1){1'b0}}};

  logic clamp;
  logic sat_q, sat_d;

  always_comb begin
    clamp = 1'b1;
    if (scaled > SAT_MAX)      y_new = SAT_MAX[PRECISION-1:0];
    else if (scaled < SAT_MIN) y_new = SAT_MIN[PRECISION-1:0];
    else begin
      clamp = 1'b0;
      y_new = scaled[PRECISION-1:0];
    end
  end

  assign sat = sat_q;
`else
  logic unused_scaled_msbs;

  assign y_new              = scaled[PRECISION-1:0];
  assign unused_scaled_msbs = ^scaled[ACC_W-1:PRECISION];
`endif

  // Sequencer: accept, 2N+1 MAC cycles, scale/commit, output strobe (which may accept again).
  always_comb begin
    state_d   = state_q;
    tap_d     = tap_q;
    acc_d     = acc_q;
    x_d       = x_q;
    chan_d    = chan_q;
    coeffs_d  = coeffs_q;
    xh_d      = xh_q;
    yh_d      = yh_q;
    y_d       = y_q;
    y_chan_d  = y_chan_q;
    y_valid_d = 1'b0;
    x_ready_d = x_ready_q;
`ifdef DF_I_TDM_SATURATE_EN
    sat_d     = 1'b0;
`endif
    unique case (state_q)
      IDLE, OUT: begin
        if (x_valid && x_ready_q) begin
          x_d       = x;
          chan_d    = x_chan;
          coeffs_d  = packed_coeffs;
          acc_d     = '0;
          tap_d     = '0;
          x_ready_d = 1'b0;
          state_d   = MAC;
        end else begin
          state_d = IDLE;
        end
      end
      MAC: begin
        acc_d = feedback ? (acc_q - prod_ext) : (acc_q + prod_ext);
        if (tap_q == TAP_W'(TAPS - 1)) state_d = SCALE;
        else                           tap_d   = tap_q + TAP_W'(1);
      end
      SCALE: begin
        // Out-of-range channels run the schedule but commit nothing.
        if (chan_hit) begin
          y_d       = y_new;
          y_chan_d  = chan_q;
          y_valid_d = 1'b1;
`ifdef DF_I_TDM_SATURATE_EN
          sat_d     = clamp;
`endif
          for (int c = 0; c < CHANNELS; c++) begin
            if (chan_q == CHAN_W'(c)) begin
              for (int k = N - 1; k > 0; k--) begin
                xh_d[c][k] = xh_q[c][k-1];
                yh_d[c][k] = yh_q[c][k-1];
              end
              xh_d[c][0] = x_q;
              yh_d[c][0] = y_new;
            end
          end
        end
        x_ready_d = 1'b1;
        state_d   = OUT;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tap_q     <= '0;
      acc_q     <= '0;
      x_q       <= '0;
      chan_q    <= '0;
      coeffs_q  <= '0;
      xh_q      <= '{default: '0};
      yh_q      <= '{default: '0};
      y_q       <= '0;
      y_chan_q  <= '0;
      y_valid_q <= 1'b0;
      x_ready_q <= 1'b1;
`ifdef DF_I_TDM_SATURATE_EN
      sat_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      tap_q     <= tap_d;
      acc_q     <= acc_d;
      x_q       <= x_d;
      chan_q    <= chan_d;
      coeffs_q  <= coeffs_d;
      xh_q      <= xh_d;
      yh_q      <= yh_d;
      y_q       <= y_d;
      y_chan_q  <= y_chan_d;
      y_valid_q <= y_valid_d;
      x_ready_q <= x_ready_d;
`ifdef DF_I_TDM_SATURATE_EN
      sat_q     <= sat_d;
`endif
    end
  end

  assign x_ready = x_ready_q;
  assign y       = y_q;
  assign y_chan  = y_chan_q;
  assign y_valid = y_valid_q;

endmodule

// File: tb/tb_df_i_tdm.sv
// Bench for df_i_tdm: vector table feeding an expected-output queue, plus timing/reset sequences.
module tb_df_i_tdm;

  logic                clk = 1'b0;
  logic                rst_n;
  logic signed [15:0]  x;
  logic [1:0]          x_chan;
  logic                x_valid;
  logic                x_ready;
  logic [11:0]         packed_coeffs;
  logic signed [15:0]  y;
  logic [1:0]          y_chan;
  logic                y_valid;
`ifdef DF_I_TDM_SATURATE_EN
  logic                sat;
  localparam logic signed [15:0] E_POS      = 16'sd32767;
  localparam logic signed [15:0] E_POS_NEXT = 16'sd16383;
  localparam logic signed [15:0] E_NEG      = 16'sh8000;
  localparam bit                 S_SAT      = 1'b1;
`else
  localparam logic signed [15:0] E_POS      = -16'sd8194;
  localparam logic signed [15:0] E_POS_NEXT = -16'sd4097;
  localparam logic signed [15:0] E_NEG      = 16'sd8192;
  localparam bit                 S_SAT      = 1'b0;
`endif

  // {b0,b1,a1} with 4-bit coefficients
  localparam logic [11:0] C_IMP = 12'h40E;  // b0=4 b1=0 a1=-2
  localparam logic [11:0] C_FIR = 12'h210;  // b0=2 b1=1 a1=0
  localparam logic [11:0] C_SAT = 12'h700;  // b0=7 b1=0 a1=0

  df_i_tdm #(
    .CHANNELS(3), .N(1), .PRECISION(16), .COEFF_WIDTH(4), .Q(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .x(x), .x_chan(x_chan), .x_valid(x_valid),
    .x_ready(x_ready), .packed_coeffs(packed_coeffs), .y(y), .y_chan(y_chan),
    .y_valid(y_valid)
`ifdef DF_I_TDM_SATURATE_EN
    , .sat(sat)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [15:0] x;
    logic [1:0]         ch;
    logic [11:0]        cf;
    bit                 has_out;
    logic signed [15:0] ey;
    bit                 esat;
  } vec_t;

  typedef struct {
    logic signed [15:0] y;
    logic [1:0]         ch;
    bit                 sat;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  int   acc_cyc[$];
  vec_t tbl[16];

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && x_valid && x_ready) acc_cyc.push_back(cyc);
  end

  // Output monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && y_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_y_valid", 32'sd1, 32'sd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("y", y, e.y);
        check("y_chan", 32'(y_chan), 32'(e.ch));
`ifdef DF_I_TDM_SATURATE_EN
        check("sat", 32'(sat), 32'(e.sat));
`endif
      end
    end
  end

  task automatic send(input logic signed [15:0] xv, input logic [1:0] ch, input logic [11:0] cf,
                      input bit push, input logic signed [15:0] ey, input bit es);
    int   n;
    exp_t e;
    n = 0;
    if (push) begin
      e.y = ey; e.ch = ch; e.sat = es;
      exp_q.push_back(e);
    end
    @(negedge clk);
    x = xv; x_chan = ch; packed_coeffs = cf; x_valid = 1'b1;
    while (!x_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!x_ready) check("send_timeout", 32'sd0, 32'sd1);
    @(posedge clk);
    #1;
    // Scramble inputs right after the accept edge: captured values must be unaffected.
    x_valid = 1'b0; packed_coeffs = ~cf; x = ~xv;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", exp_q.size(), 0);
  endtask

  initial begin
    int n;
    tbl[0]  = '{16'sd0,      2'd0, C_IMP, 1'b1, 16'sd2,     1'b0};
    tbl[1]  = '{16'sd0,      2'd1, C_IMP, 1'b1, 16'sd0,     1'b0};
    tbl[2]  = '{16'sd0,      2'd0, C_IMP, 1'b1, 16'sd1,     1'b0};
    tbl[3]  = '{16'sd0,      2'd0, C_IMP, 1'b1, 16'sd0,     1'b0};
    tbl[4]  = '{-16'sd3,     2'd1, C_IMP, 1'b1, -16'sd3,    1'b0};
    tbl[5]  = '{16'sd100,    2'd2, C_IMP, 1'b1, 16'sd100,   1'b0};
    tbl[6]  = '{16'sd0,      2'd1, C_IMP, 1'b1, -16'sd2,    1'b0};
    tbl[7]  = '{16'sd50,     2'd3, C_IMP, 1'b0, 16'sd0,     1'b0};
    tbl[8]  = '{-16'sd10,    2'd2, C_IMP, 1'b1, 16'sd40,    1'b0};
    tbl[9]  = '{16'sd0,      2'd1, C_IMP, 1'b1, -16'sd1,    1'b0};
    tbl[10] = '{16'sd0,      2'd1, C_IMP, 1'b1, -16'sd1,    1'b0};
    tbl[11] = '{16'sd8,      2'd0, C_FIR, 1'b1, 16'sd4,     1'b0};
    tbl[12] = '{16'sd0,      2'd0, C_FIR, 1'b1, 16'sd2,     1'b0};
    tbl[13] = '{16'sd32767,  2'd2, C_SAT, 1'b1, E_POS,      S_SAT};
    tbl[14] = '{16'sd0,      2'd2, C_IMP, 1'b1, E_POS_NEXT, 1'b0};
    tbl[15] = '{16'sh8000,   2'd1, C_SAT, 1'b1, E_NEG,      S_SAT};

    rst_n = 1'b0; x = '0; x_chan = '0; x_valid = 1'b0; packed_coeffs = '0;
    repeat (3) @(negedge clk);
    check("rst_y", y, 0);
    check("rst_y_chan", 32'(y_chan), 0);
    check("rst_y_valid", 32'(y_valid), 0);
    check("rst_x_ready", 32'(x_ready), 1);
    rst_n = 1'b1;

    // Impulse head with cycle-exact latency and ready timing.
    send(16'sd4, 2'd0, C_IMP, 1'b1, 16'sd4, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      check($sformatf("lat_x_ready_c%0d", k), 32'(x_ready), (k == 5) ? 1 : 0);
      check($sformatf("lat_y_valid_c%0d", k), 32'(y_valid), (k == 5) ? 1 : 0);
      @(posedge clk);
      #1;
    end

    for (int i = 0; i < 16; i++) begin
      send(tbl[i].x, tbl[i].ch, tbl[i].cf, tbl[i].has_out, tbl[i].ey, tbl[i].esat);
    end
    drain();

    // Back-to-back: x_valid held high, accepts must be 5 cycles apart.
    acc_cyc.delete();
    exp_q.push_back('{16'sd1, 2'd0, 1'b0});
    exp_q.push_back('{16'sd0, 2'd0, 1'b0});
    exp_q.push_back('{16'sd0, 2'd0, 1'b0});
    @(negedge clk);
    x = 16'sd0; x_chan = 2'd0; packed_coeffs = C_IMP; x_valid = 1'b1;
    n = 0;
    while (acc_cyc.size() < 3 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    x_valid = 1'b0;
    check("tput_accepts", acc_cyc.size(), 3);
    if (acc_cyc.size() >= 3) begin
      check("tput_gap1", acc_cyc[1] - acc_cyc[0], 5);
      check("tput_gap2", acc_cyc[2] - acc_cyc[1], 5);
    end
    drain();

    // Reset while the MAC is running: nothing comes out and all history is cleared.
    send(16'sd4, 2'd0, C_IMP, 1'b1, 16'sd4, 1'b0);
    drain();
    send(16'sd4, 2'd0, C_IMP, 1'b0, 16'sd0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_y", y, 0);
    check("midrst_y_valid", 32'(y_valid), 0);
    check("midrst_x_ready", 32'(x_ready), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    send(16'sd0, 2'd0, C_IMP, 1'b1, 16'sd0, 1'b0);
    send(16'sd0, 2'd1, C_IMP, 1'b1, 16'sd0, 1'b0);
    drain();
    repeat (8) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/df_i_tdm.md
Name: df_i_tdm

Overview:
- Time-multiplexed, multi-channel, parametrised-order Direct Form I IIR filter. Successor to the single-channel df_i.
- One shared multiply-accumulate (MAC) unit is sequenced by a state machine over 2N+1 taps.
- Holds independent x/y history per channel. Sits between ADC capture and the trigger/decimation stages of the acquisition path.
- Valid/ready on input, valid pulse on output.

Parameters:
- CHANNELS, 4: number of independent filter channels, each with its own history.
- N, 2: filter order; N feed-forward taps b1..bN plus b0, and N feedback taps a1..aN.
- PRECISION, 16: signed sample width of x and y.
- COEFF_WIDTH, 8: signed coefficient width.
- Q, 6: fractional bits of the coefficients; the result is shifted right arithmetically by Q.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- x  in  PRECISION  signed input sample.
- x_chan  in  max(1,clog2(CHANNELS))  channel index of x.
- x_valid  in  1  input sample valid.
- x_ready  out  1  block can accept a sample.
- packed_coeffs  in  (2N+1)*COEFF_WIDTH  {b0,b1..bN,a1..aN}, b0 in the MSBs. Shared by all channels.
- y  out  PRECISION  signed filtered output.
- y_chan  out  width of x_chan  channel of y.
- y_valid  out  1  single-cycle output strobe.

Behaviour:
- Transfer function: y[n] = (sum_{k=0..N} bk*x[n-k] - sum_{k=1..N} ak*y[n-k]) >>> Q.
  - The shift is arithmetic (floor); there is no rounding.
- Accumulator: signed, ACC_W = PRECISION+COEFF_WIDTH+clog2(2N+1)+1 bits. It never overflows internally.
- Reset values: y=0, y_chan=0, y_valid=0, x_ready=1, state=IDLE, all history registers=0.
- FSM states: IDLE, MAC, SCALE, OUT.
  - IDLE: x_ready=1. On x_valid&&x_ready, register x, x_chan and packed_coeffs, clear the accumulator, go to MAC.
  - MAC: one product per cycle over 2N+1 cycles, in order b0*x, b1..bN * x history, then a1..aN * y history (subtracted). After the last tap, go to SCALE.
  - SCALE: shift by Q, then saturate or wrap to PRECISION (see Optional Feature). Go to OUT.
  - OUT: drive y and y_chan, pulse y_valid for 1 cycle. Shift the channel's x history (new x enters at x[n-1]) and y history (new y enters at y[n-1]). Set x_ready=1 and go to IDLE.
- Latency: accept at edge 0; y_valid is high in cycle 2N+3. Throughput is one sample per 2N+3 cycles.
- No output backpressure. y holds its value until the next OUT.
- Coefficients are captured at accept. Changing packed_coeffs mid-computation has no effect on that sample.
- x_chan >= CHANNELS: the sample is accepted and the FSM runs. No y_valid is produced and no history changes.
- x_valid with x_ready=0 is ignored; the source must hold the sample.
- Channels are fully isolated; a sample on one channel never alters another channel's history.
- Reset mid-operation: any in-flight sample is discarded with no y_valid. All histories are zeroed and the FSM returns to IDLE.

Optional Feature:
- Macro: DF_I_TDM_SATURATE_EN.
- Defined: the SCALE result clamps to [-2^(PRECISION-1), 2^(PRECISION-1)-1]. An extra output port sat (1 bit, reset 0) pulses with y_valid when clamping occurred. The clamped value is the one written to the y history.
- Undefined: the result is truncated to the low PRECISION bits (two's-complement wrap), and the sat port does not exist.

Test Plan:
- Impulse (CHANNELS=2, N=1, PRECISION=16, COEFF_WIDTH=4, Q=2, coeffs {b0=4, b1=0, a1=-2}): x=4 on ch0, then x=0 three times -> y = 4, 2, 1, 0, all with y_chan=0.
- Latency/handshake (same config): accept at edge 0 -> y_valid high exactly in cycle 5. x_ready is low in cycles 1-4 and high again in cycle 5. x_valid held high continuously -> one accept every 5 cycles.
- Isolation: after the ch0 impulse x=4, send x=0 on ch1 -> y=0 on ch1. The next ch0 sample x=0 still gives y=2.
- Saturation (b0=7, b1=0, a1=0, Q=2, PRECISION=16): x=32767 -> with macro y=32767 and sat=1; without macro y=-8194.
- Invalid channel (CHANNELS=2, x_chan width 1 -> set CHANNELS=3, x_chan=3): sample accepted, no y_valid, x_ready returns high after 5 cycles, and subsequent channel outputs are unchanged.
- Reset mid-MAC: drop rst_n low in cycle 2 after accepting x=4 -> no y_valid. After release, x=0 on ch0 gives y=0, confirming the history was cleared.
